// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and constants for the 16-lane TDM demultiplexer.
package tdm_demux_pkg;

  // Framing state: IDLE waits for a start-of-frame, RUN steers bits into slots.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int         SEL_W_DEFAULT = 4;
  localparam logic [3:0] LAST_SLOT     = 4'd15;

endpackage

// File: rtl/tdm_demux16_dec24.sv
// dec24: combinational 2-to-4 one-hot decoder with enable.
// Building block for the hierarchical 4-to-16 slot decoder.
module dec24 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // One-hot of sel when enabled, all zero otherwise.
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: time-division demultiplexer, receive side of the 16:1 select mux.
// One serial bit per valid cycle is steered into lane 'slot'; a full frame is
// published on 'lanes' with a one-cycle frame_valid strobe.
// Optional build macro: TDM_DEMUX_STRICT_SOF_EN -- when defined, a slot-0 bit
// without sof while running is a framing error (drop bit, return to IDLE);
// when undefined, such a bit continues the stream as the next frame's slot 0.
module tdm_demux16
  import tdm_demux_pkg::*;
#(
  parameter  int SEL_W = SEL_W_DEFAULT,
  localparam int LANES = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [LANES-1:0] lanes,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic [LANES-1:0] slot_onehot,
  output logic             sync_err
);

  localparam logic [SEL_W-1:0] LAST = (SEL_W == SEL_W_DEFAULT) ? SEL_W'(LAST_SLOT)
                                                              : SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   slot_d;
  logic [LANES-2:0]   shadow_q, shadow_d;   // slots 0..LANES-2; last bit goes straight to lanes
  logic [LANES-1:0]   lanes_d;
  logic [LANES-1:0]   onehot_d;
  logic               fv_d, se_d;
  logic               dec_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath update: framing rules per incoming valid bit.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot;
    shadow_d = shadow_q;
    lanes_d  = lanes;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid && sof) begin
          shadow_d[0] = din;
          slot_d      = ONE;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          if (sof) begin
            // sof anywhere but slot 0 abandons the partial frame
            if (slot != '0) begin
              se_d     = 1'b1;
              shadow_d = '0;
            end
            shadow_d[0] = din;
            slot_d      = ONE;
          end else if (slot == '0) begin
`ifdef TDM_DEMUX_STRICT_SOF_EN
            se_d    = 1'b1;
            state_d = IDLE;
`else
            shadow_d[0] = din;
            slot_d      = ONE;
`endif
          end else if (slot == LAST) begin
            lanes_d = {din, shadow_q};
            fv_d    = 1'b1;
            slot_d  = '0;
          end else begin
            shadow_d[slot] = din;
            slot_d         = slot + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode enable: one-hot is only live while running.
  always_comb begin
    dec_en = (state_d == RUN);
  end

  // Slot decoder, computed from the next slot so it registers alongside slot.
  generate
    if (SEL_W == 4) begin : g_tree
      logic [3:0] hi;
      dec24 u_hi (.en(dec_en), .sel(slot_d[3:2]), .y(hi));
      for (genvar g = 0; g < 4; g++) begin : g_lo
        dec24 u_lo (.en(hi[g]), .sel(slot_d[1:0]), .y(onehot_d[4*g +: 4]));
      end
    end else begin : g_shift
      assign onehot_d = dec_en ? (LANES'(1) << slot_d) : '0;
    end
  endgenerate

  // Datapath and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= '0;
      slot_onehot <= '0;
      shadow_q    <= '0;
      lanes       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      slot        <= slot_d;
      slot_onehot <= onehot_d;
      shadow_q    <= shadow_d;
      lanes       <= lanes_d;
      frame_valid <= fv_d;
      sync_err    <= se_d;
    end
  end

endmodule
